// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline register: FSM state encoding
// and the occupancy width/decoder used by the parent.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } skid_state_t;

    localparam int OCC_W = 2;

    // Held-beat count for a given buffer state.
    function automatic logic [OCC_W-1:0] occ_of(input skid_state_t s);
        logic [OCC_W-1:0] occ;
        case (s)
            S_EMPTY: occ = 2'd0;
            S_ONE:   occ = 2'd1;
            S_FULL:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Enabled WIDTH-bit storage register with asynchronous active-high reset to 0.
// Holds its value whenever en is low.
module pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Load new data only when enabled.
    always_comb begin
        if (en) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    // Storage flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= {WIDTH{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid buffer: main holds the head beat, skid absorbs the
// one beat accepted while the registered in_ready had not yet dropped.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [OCC_W-1:0]     occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    skid_state_t          state_q;
    skid_state_t          state_d;
    logic                 in_fire_s;
    logic                 out_fire_s;
    logic                 main_en_s;
    logic                 main_from_skid_s;
    logic                 skid_en_s;
    logic [WIDTH-1:0]     main_d;
    logic [WIDTH-1:0]     main_q;
    logic [WIDTH-1:0]     skid_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and storage enables; flush overrides any transfer.
    always_comb begin
        state_d          = state_q;
        main_en_s        = 1'b0;
        main_from_skid_s = 1'b0;
        skid_en_s        = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire_s) begin
                        main_en_s = 1'b1;
                        state_d   = S_ONE;
                    end else begin
                        state_d   = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_en_s = 1'b1;
                        state_d   = S_ONE;
                    end else if (in_fire_s) begin
                        skid_en_s = 1'b1;
                        state_d   = S_FULL;
                    end else if (out_fire_s) begin
                        state_d   = S_EMPTY;
                    end else begin
                        state_d   = S_ONE;
                    end
                end
                S_FULL: begin
                    if (out_fire_s) begin
                        main_en_s        = 1'b1;
                        main_from_skid_s = 1'b1;
                        state_d          = S_ONE;
                    end else begin
                        state_d          = S_FULL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        out_valid  = (state_q != S_EMPTY);
        in_ready   = (state_q != S_FULL) & ~reset;
        occupancy  = occ_of(state_q);
        in_fire_s  = in_valid & in_ready;
        out_fire_s = out_valid & out_ready;
    end

    // Main register source: refill from skid when draining a full buffer.
    always_comb begin
        if (main_from_skid_s) begin
            main_d = skid_q;
        end else begin
            main_d = in_data;
        end
    end

    pipe_reg #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en_s),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en_s),
        .d     (in_data),
        .q     (skid_q)
    );

    // Saturating count of stalled head cycles.
    always_comb begin
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_data  = main_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg; a second instance with a
// 4-bit stall counter shares the stimulus to exercise saturation.
module tb_pipe_skid_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_data4;
    logic [1:0]  occupancy4;
    logic [3:0]  stall_cnt4;

    int checks;
    int errors;

    pipe_skid_reg #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    pipe_skid_reg #(.WIDTH(32), .CNT_WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_data   (in_data),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_data  (out_data4),
        .occupancy (occupancy4),
        .stall_cnt (stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'hxxxx_xxxx;
        out_ready = 1'b0;

        // 1. reset held for 3 cycles
        repeat (3) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_occ",       {30'd0, occupancy}, 32'd0);
        chk("rst_stall",     {16'd0, stall_cnt}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);

        // 2. streaming 1..8 at one beat per cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = i;
            step();
            chk("stream_data", out_data, i);
            chk("stream_occ",  {30'd0, occupancy}, 32'd1);
        end
        in_valid = 1'b0;
        in_data  = 32'hxxxx_xxxx;
        step();
        chk("stream_drain_occ", {30'd0, occupancy}, 32'd0);
        chk("stream_stall",     {16'd0, stall_cnt}, 32'd0);

        // 3. backpressure with two beats
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        chk("bp_occ1", {30'd0, occupancy}, 32'd1);
        in_data = 32'hB;
        step();
        chk("bp_occ2",      {30'd0, occupancy}, 32'd2);
        chk("bp_in_ready0", {31'd0, in_ready},  32'd0);
        in_valid = 1'b0;
        in_data  = 32'hxxxx_xxxx;
        repeat (4) begin
            step();
            chk("bp_hold_data", out_data, 32'hA);
        end
        chk("bp_stall5", {16'd0, stall_cnt}, 32'd5);
        out_ready = 1'b1;
        chk("bp_head_a", out_data, 32'hA);
        step();
        chk("bp_head_b", out_data, 32'hB);
        chk("bp_occ_b",  {30'd0, occupancy}, 32'd1);
        step();
        chk("bp_empty_occ",   {30'd0, occupancy}, 32'd0);
        chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_stall_hold",  {16'd0, stall_cnt}, 32'd5);

        // 4. flush while full, then while holding one beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        chk("fl_full", {30'd0, occupancy}, 32'd2);
        flush   = 1'b1;
        in_data = 32'hC;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'hxxxx_xxxx;
        chk("fl_valid0", {31'd0, out_valid}, 32'd0);
        chk("fl_occ0",   {30'd0, occupancy}, 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h33;
        step();
        chk("fl_next_beat", out_data, 32'h33);
        in_data = 32'h44;
        step();
        chk("fl_beat44", out_data, 32'h44);
        out_ready = 1'b0;
        flush     = 1'b1;
        in_data   = 32'hC;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'hxxxx_xxxx;
        chk("fl1_occ0",  {30'd0, occupancy}, 32'd0);
        chk("fl1_stall", {16'd0, stall_cnt}, 32'd8);
        out_ready = 1'b1;
        step();
        chk("fl1_no_ghost", {31'd0, out_valid}, 32'd0);

        // 5. async reset between edges while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        step();
        in_data = 32'h66;
        step();
        in_valid = 1'b0;
        in_data  = 32'hxxxx_xxxx;
        chk("ar_full", {30'd0, occupancy}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid0", {31'd0, out_valid}, 32'd0);
        chk("ar_ready0", {31'd0, in_ready},  32'd0);
        chk("ar_occ0",   {30'd0, occupancy}, 32'd0);
        chk("ar_data0",  out_data,           32'd0);
        chk("ar_stall0", {16'd0, stall_cnt}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("ar_ready1", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        step();
        chk("ar_data77", out_data, 32'h77);
        in_valid = 1'b0;
        in_data  = 32'hxxxx_xxxx;
        step();
        chk("ar_drain", {30'd0, occupancy}, 32'd0);

        // 6. stall counter saturation on the 4-bit instance
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h88;
        step();
        in_valid = 1'b0;
        in_data  = 32'hxxxx_xxxx;
        repeat (15) step();
        chk("sat_at15", {28'd0, stall_cnt4}, 32'd15);
        repeat (5) step();
        chk("sat_hold15", {28'd0, stall_cnt4}, 32'd15);
        chk("sat_wide20", {16'd0, stall_cnt},  32'd20);
        chk("sat_data",   out_data4,           32'h88);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
